// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, the long-latency result entry layout and default sizing for rf_wport_arbiter.
package rf_wport_arbiter_pkg;

    localparam int unsigned GprW         = 5;
    localparam int unsigned Xlen         = 32;
    localparam int unsigned DefDepth     = 4;
    localparam int unsigned DefStarveMax = 8;

    typedef struct packed {
        logic [Xlen-1:0] pc;
        logic [GprW-1:0] dest;
        logic [Xlen-1:0] wdata;
    } lu_entry_t;

    localparam int unsigned LuEntryW = Xlen + GprW + Xlen;
    // Bit position of the dest field inside a packed lu_entry_t.
    localparam int unsigned LuDestLsb = Xlen;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bundles the writeback, long-latency, register-file and difftest signals of rf_wport_arbiter.
// Hazard lookup signals exist only when RF_WPORT_FWD_EN is defined.
interface rf_wport_arbiter_if;
    import rf_wport_arbiter_pkg::*;

    logic            p_valid;
    logic            p_we;
    logic [GprW-1:0] p_dest;
    logic [Xlen-1:0] p_wdata;
    logic [Xlen-1:0] p_pc;
    logic            p_ready;
    logic            flush;

    logic            lu_valid;
    logic            lu_ready;
    logic [GprW-1:0] lu_dest;
    logic [Xlen-1:0] lu_wdata;
    logic [Xlen-1:0] lu_pc;
    logic            lu_idle;

    logic            rf_we;
    logic [GprW-1:0] rf_waddr;
    logic [Xlen-1:0] rf_wdata;

    logic [Xlen-1:0] debug_wb_pc;
    logic [3:0]      debug_wb_rf_we;
    logic [GprW-1:0] debug_wb_rf_wnum;
    logic [Xlen-1:0] debug_wb_rf_wdata;

`ifdef RF_WPORT_FWD_EN
    logic [GprW-1:0] hz_raddr1;
    logic [GprW-1:0] hz_raddr2;
    logic            hz_hit1;
    logic            hz_hit2;
`endif

    modport master (
        output p_valid, p_we, p_dest, p_wdata, p_pc, flush,
        output lu_valid, lu_dest, lu_wdata, lu_pc,
        input  p_ready, lu_ready, lu_idle,
        input  rf_we, rf_waddr, rf_wdata,
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
`ifdef RF_WPORT_FWD_EN
        ,
        output hz_raddr1, hz_raddr2,
        input  hz_hit1, hz_hit2
`endif
    );

    modport slave (
        input  p_valid, p_we, p_dest, p_wdata, p_pc, flush,
        input  lu_valid, lu_dest, lu_wdata, lu_pc,
        output p_ready, lu_ready, lu_idle,
        output rf_we, rf_waddr, rf_wdata,
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
`ifdef RF_WPORT_FWD_EN
        ,
        input  hz_raddr1, hz_raddr2,
        output hz_hit1, hz_hit2
`endif
    );

endinterface

// File: rtl/rf_wport_arbiter_wb_result_fifo.sv
// Synchronous FIFO for long-latency results; extra pointer bit separates full from empty.
// With RF_WPORT_FWD_EN it also exports per-entry valid/dest for hazard lookup.
module wb_result_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned WIDTH = LuEntryW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty
`ifdef RF_WPORT_FWD_EN
    ,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [DEPTH-1:0][GprW-1:0]     entry_dest
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[PtrW-1:0]] <= wdata;
    end

`ifdef RF_WPORT_FWD_EN
    logic [PtrW:0] count;
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        entry_valid = '0;
        entry_dest  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PtrW-1:0] off;
            // Distance from the head, modulo DEPTH.
            off            = PtrW'(i) - rd_ptr_q[PtrW-1:0];
            entry_valid[i] = ({1'b0, off} < count);
            entry_dest[i]  = mem[i][LuDestLsb +: GprW];
        end
    end
`endif

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write port arbiter: writeback stage has priority, queued long-latency results
// drain into free slots, and an age counter forces a drain. Optional RF_WPORT_FWD_EN hazard lookup.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned STARVE_MAX = DefStarveMax
) (
    input logic                clk,
    input logic                rst,
    rf_wport_arbiter_if.slave  bus
);

    localparam int unsigned    CntW    = $clog2(STARVE_MAX) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STARVE_MAX - 1);

    logic                fifo_full, fifo_empty;
    logic [LuEntryW-1:0] head_bits;
    lu_entry_t           head, push_entry;
    logic                p_req, lu_gnt, lu_push;

    logic [CntW-1:0]     age_q, age_d;
    logic                force_q, force_d;

    logic                sel_valid;
    logic [GprW-1:0]     sel_dest;
    logic [Xlen-1:0]     sel_wdata, sel_pc;

    logic                rf_we_q;
    logic [GprW-1:0]     rf_waddr_q;
    logic [Xlen-1:0]     rf_wdata_q, rf_pc_q;

    assign bus.p_ready  = !force_q;
    assign bus.lu_ready = !fifo_full;
    assign bus.lu_idle  = fifo_empty;

    assign p_req   = bus.p_valid && bus.p_we && !bus.flush && !force_q;
    assign lu_gnt  = !fifo_empty && (force_q || !p_req);
    assign lu_push = bus.lu_valid && !fifo_full;

    assign push_entry = '{pc: bus.lu_pc, dest: bus.lu_dest, wdata: bus.lu_wdata};
    assign head       = lu_entry_t'(head_bits);

`ifdef RF_WPORT_FWD_EN
    logic [DEPTH-1:0]           entry_valid;
    logic [DEPTH-1:0][GprW-1:0] entry_dest;
`endif

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LuEntryW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (lu_push),
        .wdata       (push_entry),
        .pop         (lu_gnt),
        .rdata       (head_bits),
        .full        (fifo_full),
        .empty       (fifo_empty)
`ifdef RF_WPORT_FWD_EN
        ,
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
`endif
    );

    // force is a one-cycle pulse; the forced grant itself clears the counter.
    always_comb begin
        age_d   = age_q;
        force_d = 1'b0;
        if (fifo_empty || lu_gnt) begin
            age_d = '0;
        end else if (p_req) begin
            if (age_q == CntLast) begin
                force_d = 1'b1;
                age_d   = '0;
            end else begin
                age_d = age_q + 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = p_req || lu_gnt;
        sel_dest  = head.dest;
        sel_wdata = head.wdata;
        sel_pc    = head.pc;
        if (p_req) begin
            sel_dest  = bus.p_dest;
            sel_wdata = bus.p_wdata;
            sel_pc    = bus.p_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q      <= '0;
            force_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_pc_q    <= '0;
        end else begin
            age_q   <= age_d;
            force_q <= force_d;
            // r0 writes consume the slot but never assert the enable.
            rf_we_q <= sel_valid && (sel_dest != '0);
            if (sel_valid) begin
                rf_waddr_q <= sel_dest;
                rf_wdata_q <= sel_wdata;
                rf_pc_q    <= sel_pc;
            end
        end
    end

    assign bus.rf_we             = rf_we_q;
    assign bus.rf_waddr          = rf_waddr_q;
    assign bus.rf_wdata          = rf_wdata_q;
    assign bus.debug_wb_pc       = rf_pc_q;
    assign bus.debug_wb_rf_we    = {4{rf_we_q}};
    assign bus.debug_wb_rf_wnum  = rf_waddr_q;
    assign bus.debug_wb_rf_wdata = rf_wdata_q;

`ifdef RF_WPORT_FWD_EN
    always_comb begin
        bus.hz_hit1 = 1'b0;
        bus.hz_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_dest[i] == bus.hz_raddr1 && bus.hz_raddr1 != '0) begin
                bus.hz_hit1 = 1'b1;
            end
            if (entry_valid[i] && entry_dest[i] == bus.hz_raddr2 && bus.hz_raddr2 != '0) begin
                bus.hz_hit2 = 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Arbitrates the single architectural register-file write port between two requesters. One requester is the in-order writeback stage. The other is a long-latency unit (divider / uncached load) that returns results out of band. Long-latency results are queued in a small FIFO and drained into free port slots. An age counter guarantees the queue is never starved. Sits between the writeback stage and the register file; also drives the difftest debug_wb_* signals.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
STARVE_MAX, 8, consecutive blocked cycles of a non-empty FIFO head before a forced LU grant

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-high
p_valid  in  1  writeback-stage instruction valid
p_we  in  1  instruction writes a GPR
p_dest  in  5  GPR index
p_wdata  in  32  write data
p_pc  in  32  instruction PC
p_ready  out  1  arbiter accepts pipeline request this cycle
flush  in  1  exception flush; kills the pipeline request this cycle
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept (= !full)
lu_dest  in  5  GPR index
lu_wdata  in  32  result
lu_pc  in  32  originating PC
lu_idle  out  1  FIFO empty
rf_we  out  1  registered RF write enable
rf_waddr  out  5  registered RF write index
rf_wdata  out  32  registered RF write data
debug_wb_pc  out  32  PC of the write presented on rf_*
debug_wb_rf_we  out  4  {4{rf_we}}
debug_wb_rf_wnum  out  5  = rf_waddr
debug_wb_rf_wdata  out  32  = rf_wdata

Behaviour:
- Reset: FIFO empty, age counter 0, force 0. All rf_*/debug outputs 0. p_ready=1, lu_ready=1, lu_idle=1. A reset asserted mid-operation discards queued entries.
- Pipeline write request: p_req = p_valid & p_we & !flush & p_ready.
- p_ready = !force. It is combinational from registered state only and never depends on p_valid.
- A pipeline instruction with p_we=0 is accepted but does not use the port.
- LU grant: lu_gnt = !empty & (force | !p_req). At most one write per cycle.
- Enqueue when lu_valid & lu_ready. An entry enqueued in cycle t is eligible at t+1, at the earliest. rf_we is high in the cycle after the grant, so LU latency is >=2 cycles and pipeline latency is 1 cycle.
- Simultaneous enqueue and dequeue is legal when not full. When full, lu_ready=0 even if a dequeue occurs that cycle (no bypass). Pointers wrap modulo DEPTH; the full/empty distinction uses an extra pointer bit.
- Age counter:
  - Clears on a dequeue or when the FIFO is empty.
  - Otherwise increments when the head is blocked (!empty & p_req).
  - When the counter reaches STARVE_MAX-1 and is blocked again, force is set for exactly the next cycle. During that cycle p_ready=0, the head is written, and the counter and force clear.
- dest==0 from either source: the slot is consumed, rf_we stays 0, and the debug signals show we=0.
- flush does not affect the FIFO: queued LU results are architecturally committed and still retire.
- rf_* and debug_* outputs are registered. When no grant occurs, rf_we=0 and the data/index/pc fields hold their previous values.
- Dequeue order is strictly FIFO.

Optional Feature:
RF_WPORT_FWD_EN:
- When defined, adds hz_raddr1/hz_raddr2 (in, 5) and hz_hit1/hz_hit2 (out, 1).
- hz_hitN is combinational. It is 1 when any valid FIFO entry has dest == hz_raddrN != 0, so decode can stall on a pending long-latency write.
- When undefined, these ports and the compare logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - GPR index width (5) and XLEN (32).
  - An LU-entry struct/bus width {pc,dest,wdata} = 69 bits.
  - The default DEPTH/STARVE_MAX constants.
- One natural sub-module, wb_result_fifo: a synchronous FIFO with full/empty, parameterised on DEPTH and width. Under RF_WPORT_FWD_EN it also exposes per-entry valid/dest for the hazard compare.

Test Plan:
- Pipeline-only path: p_valid=1, p_we=1, dest=5, data=0x1234 at cycle t with an empty FIFO → rf_we=1, waddr=5, wdata=0x1234 at t+1; debug_wb_rf_we=4'hF.
- LU drains into an idle slot: lu_valid at t (dest=7, data=0xAA), p_valid=0 → rf_we with waddr=7 at t+2; lu_idle returns to 1 at t+2.
- Pipeline priority and starvation: 1 LU entry queued, pipeline writes every cycle, STARVE_MAX=8 → 8 pipeline writes. Then p_ready=0 for one cycle and the LU write appears. Pipeline writes resume afterwards, with no pipeline beat lost (p_valid held).
- FIFO full and wrap: 4 LU enqueues while the pipeline saturates the port → lu_ready=0 after the 4th. Then 6 total entries are pushed across wrap-around; all 6 retire in order with correct data.
- Flush and r0: flush=1 with p_valid, p_we=1, dest=3 → no write, and a queued LU entry is written in that slot. A separate dest=0 request → rf_we=0 and the slot is consumed.
- Reset mid-queue: 3 entries queued, rst=1 for one cycle → lu_idle=1, rf_we=0, and none of the 3 entries is ever written. Under RF_WPORT_FWD_EN, with entry dest=9 queued, hz_raddr1=9 → hz_hit1=1, and hz_raddr1=0 → hz_hit1=0.
